// File: rtl/rv_decode_exec.sv
// rv_decode_exec: RV32I control decode, immediate generation, ALU and branch compare.
// Optional BRANCH_EXT_EN adds blt/bge/bltu/bgeu branch compares.
module rv_decode_exec #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            enable,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  output logic [10:0]     signals,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] aluResult,
  output logic            branchFromAlu,
  output logic            branchTaken,
  output logic [XLEN-1:0] result_q,
  output logic            taken_q
);

  typedef struct packed {
    logic [2:0] aluop;
    logic       branch;
    logic       memwrite;
    logic       memread;
    logic       regwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] immsel;
  } ctrl_t;

  localparam logic [2:0] OP_MEM = 3'b000;
  localparam logic [2:0] OP_BR  = 3'b001;
  localparam logic [2:0] OP_R   = 3'b010;
  localparam logic [2:0] OP_I   = 3'b011;
  localparam logic [2:0] OP_LUI = 3'b100;

  ctrl_t           ctrl;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [3:0]      func;
  logic [XLEN-1:0] opb;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_rt;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      opc == 7'b0110011: ctrl = ctrl_t'(11'h210);
      opc == 7'b0010011: ctrl = ctrl_t'(11'h314);
      opc == 7'b0000011: ctrl = ctrl_t'(11'h03C);
      opc == 7'b0100011: ctrl = ctrl_t'(11'h045);
      opc == 7'b1100011: ctrl = ctrl_t'(11'h182);
      opc == 7'b0110111: ctrl = ctrl_t'(11'h417);
      default:           ctrl = '0;
    endcase
  end

  assign signals = ctrl;

  always_comb begin
    imm = '0;
    unique case (ctrl.immsel)
      2'b00: imm = {{20{instr[31]}}, instr[31:20]};
      2'b01: imm = {{20{instr[31]}}, instr[31:25],
                    instr[11:7]};
      2'b10: imm = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      2'b11: imm = {instr[31:12], 12'b0};
      default: imm = '0;
    endcase
  end

  assign opb   = ctrl.alusrc ? imm : dataB;
  assign shamt = opb[4:0];

  // Immediate ALU ops only honour instr[30] for srli/srai
  always_comb begin
    func = {instr[30], f3};
    if (ctrl.aluop == OP_I && f3 != 3'b101)
      func = {1'b0, f3};
  end

  always_comb begin
    alu_rt = '0;
    casez (func)
      4'b0000: alu_rt = dataA + opb;
      4'b1000: alu_rt = dataA - opb;
      4'b?001: alu_rt = dataA << shamt;
      4'b?010: alu_rt = {31'b0,
                         $signed(dataA) < $signed(opb)};
      4'b?011: alu_rt = {31'b0, dataA < opb};
      4'b?100: alu_rt = dataA ^ opb;
      4'b0101: alu_rt = dataA >> shamt;
      4'b1101: alu_rt = $signed(dataA) >>> shamt;
      4'b?110: alu_rt = dataA | opb;
      4'b?111: alu_rt = dataA & opb;
      default: alu_rt = '0;
    endcase
  end

  always_comb begin
    aluResult = '0;
    unique case (ctrl.aluop)
      OP_MEM:  aluResult = dataA + opb;
      OP_BR:   aluResult = dataA - opb;
      OP_R:    aluResult = alu_rt;
      OP_I:    aluResult = alu_rt;
      OP_LUI:  aluResult = opb;
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    branchFromAlu = 1'b0;
    if (ctrl.aluop == OP_BR) begin
      case (f3)
        3'b000: branchFromAlu = (dataA == opb);
        3'b001: branchFromAlu = (dataA != opb);
`ifdef BRANCH_EXT_EN
        3'b100: branchFromAlu =
          $signed(dataA) < $signed(opb);
        3'b101: branchFromAlu =
          $signed(dataA) >= $signed(opb);
        3'b110: branchFromAlu = dataA < opb;
        3'b111: branchFromAlu = dataA >= opb;
`endif
        default: branchFromAlu = 1'b0;
      endcase
    end
  end

  assign branchTaken = ctrl.branch & branchFromAlu;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      result_q <= '0;
      taken_q  <= 1'b0;
    end else if (enable) begin
      result_q <= aluResult;
      taken_q  <= branchTaken;
    end
  end

endmodule

// File: tb/tb_rv_decode_exec.sv
// tb_rv_decode_exec: directed checks of decode, immediates, ALU,
// branch compare and the registered output stage.
module tb_rv_decode_exec;

  logic        clock;
  logic        clear;
  logic        enable;
  logic [31:0] instr;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [10:0] signals;
  logic [31:0] imm;
  logic [31:0] aluResult;
  logic        branchFromAlu;
  logic        branchTaken;
  logic [31:0] result_q;
  logic        taken_q;

  int checks = 0;
  int errors = 0;

  rv_decode_exec dut (
    .clock        (clock),
    .clear        (clear),
    .enable       (enable),
    .instr        (instr),
    .dataA        (dataA),
    .dataB        (dataB),
    .signals      (signals),
    .imm          (imm),
    .aluResult    (aluResult),
    .branchFromAlu(branchFromAlu),
    .branchTaken  (branchTaken),
    .result_q     (result_q),
    .taken_q      (taken_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic [31:0] i,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clock);
    instr = i;
    dataA = a;
    dataB = b;
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (result_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got %h exp %h", result_q, 32'h0);
    end
    checks++;
    if (taken_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_taken got %b exp 0", taken_q);
    end
    @(negedge clock);
    clear = 1'b1;
  endtask

  task automatic test_itype;
    drive(32'h00a00093, 32'h0, 32'h0);
    checks++;
    if (signals !== 11'h314) begin
      errors++;
      $display("FAIL addi_sig got %h exp %h", signals, 11'h314);
    end
    checks++;
    if (imm !== 32'd10) begin
      errors++;
      $display("FAIL addi_imm got %h exp %h", imm, 32'd10);
    end
    checks++;
    if (aluResult !== 32'd10 || branchTaken !== 1'b0) begin
      errors++;
      $display("FAIL addi_res got %h/%b exp 0000000a/0",
               aluResult, branchTaken);
    end
    // instr[30] set on addi must not turn it into a subtract
    drive(32'h40000093, 32'd5, 32'h0);
    checks++;
    if (aluResult !== 32'd1029) begin
      errors++;
      $display("FAIL addi_b30 got %h exp %h", aluResult, 32'd1029);
    end
    drive(32'h4040d093, 32'h80000000, 32'h0);
    checks++;
    if (aluResult !== 32'hF8000000) begin
      errors++;
      $display("FAIL srai got %h exp %h", aluResult, 32'hF8000000);
    end
    drive(32'h0040d093, 32'h80000000, 32'h0);
    checks++;
    if (aluResult !== 32'h08000000) begin
      errors++;
      $display("FAIL srli got %h exp %h", aluResult, 32'h08000000);
    end
  endtask

  task automatic test_mem;
    drive(32'h00102023, 32'h0, 32'd10);
    checks++;
    if (signals !== 11'h045) begin
      errors++;
      $display("FAIL sw_sig got %h exp %h", signals, 11'h045);
    end
    checks++;
    if (imm !== 32'h0 || aluResult !== 32'h0) begin
      errors++;
      $display("FAIL sw_res got %h/%h exp 0/0", imm, aluResult);
    end
    drive(32'h00402203, 32'h0, 32'h0);
    checks++;
    if (signals !== 11'h03C) begin
      errors++;
      $display("FAIL lw_sig got %h exp %h", signals, 11'h03C);
    end
    checks++;
    if (imm !== 32'd4 || aluResult !== 32'd4) begin
      errors++;
      $display("FAIL lw_res got %h/%h exp 4/4", imm, aluResult);
    end
  endtask

  task automatic test_rtype;
    drive(32'h004182b3, 32'd10, 32'd20);
    checks++;
    if (signals !== 11'h210) begin
      errors++;
      $display("FAIL add_sig got %h exp %h", signals, 11'h210);
    end
    checks++;
    if (aluResult !== 32'd30) begin
      errors++;
      $display("FAIL add_res got %h exp %h", aluResult, 32'd30);
    end
    drive(32'h404182b3, 32'd10, 32'd20);
    checks++;
    if (aluResult !== 32'hFFFFFFF6) begin
      errors++;
      $display("FAIL sub_res got %h exp %h", aluResult, 32'hFFFFFFF6);
    end
    drive(32'h0041a2b3, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (aluResult !== 32'd1) begin
      errors++;
      $display("FAIL slt got %h exp %h", aluResult, 32'd1);
    end
    drive(32'h0041b2b3, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (aluResult !== 32'd0) begin
      errors++;
      $display("FAIL sltu got %h exp %h", aluResult, 32'd0);
    end
    drive(32'h0041f2b3, 32'h0F0F00FF, 32'h00FF0F0F);
    checks++;
    if (aluResult !== 32'h000F000F) begin
      errors++;
      $display("FAIL and got %h exp %h", aluResult, 32'h000F000F);
    end
  endtask

  task automatic test_lui_default;
    drive(32'h12345037, 32'h0, 32'hDEADBEEF);
    checks++;
    if (signals !== 11'h417 || imm !== 32'h12345000) begin
      errors++;
      $display("FAIL lui_dec got %h/%h exp 417/12345000",
               signals, imm);
    end
    checks++;
    if (aluResult !== 32'h12345000) begin
      errors++;
      $display("FAIL lui_res got %h exp %h", aluResult, 32'h12345000);
    end
    drive(32'h0000107f, 32'd3, 32'd3);
    checks++;
    if (signals !== 11'h000 || branchTaken !== 1'b0) begin
      errors++;
      $display("FAIL bad_op got %h/%b exp 000/0", signals, branchTaken);
    end
    checks++;
    if (aluResult !== 32'd6) begin
      errors++;
      $display("FAIL bad_op_res got %h exp %h", aluResult, 32'd6);
    end
  endtask

  task automatic test_branch;
    logic exp_blt;
    drive(32'h00209463, 32'd1, 32'd2);
    checks++;
    if (signals !== 11'h182 || imm !== 32'd8) begin
      errors++;
      $display("FAIL bne_dec got %h/%h exp 182/8", signals, imm);
    end
    checks++;
    if (branchTaken !== 1'b1 || aluResult !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL bne_ne got %b/%h exp 1/ffffffff",
               branchTaken, aluResult);
    end
    drive(32'h00209463, 32'd1, 32'd1);
    checks++;
    if (branchTaken !== 1'b0) begin
      errors++;
      $display("FAIL bne_eq got %b exp 0", branchTaken);
    end
    drive(32'h00208463, 32'd7, 32'd7);
    checks++;
    if (branchTaken !== 1'b1) begin
      errors++;
      $display("FAIL beq_eq got %b exp 1", branchTaken);
    end
`ifdef BRANCH_EXT_EN
    exp_blt = 1'b1;
`else
    exp_blt = 1'b0;
`endif
    drive(32'h0020c463, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (branchTaken !== exp_blt || branchFromAlu !== exp_blt) begin
      errors++;
      $display("FAIL blt got %b/%b exp %b", branchTaken,
               branchFromAlu, exp_blt);
    end
    drive(32'h0020e463, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (branchTaken !== 1'b0) begin
      errors++;
      $display("FAIL bltu got %b exp 0", branchTaken);
    end
  endtask

  task automatic test_output_stage;
    enable = 1'b1;
    drive(32'h004182b3, 32'd10, 32'd20);
    @(posedge clock);
    #1;
    checks++;
    if (result_q !== 32'd30 || taken_q !== 1'b0) begin
      errors++;
      $display("FAIL load_add got %h/%b exp 1e/0", result_q, taken_q);
    end
    drive(32'h00209463, 32'd1, 32'd2);
    @(posedge clock);
    #1;
    checks++;
    if (result_q !== 32'hFFFFFFFF || taken_q !== 1'b1) begin
      errors++;
      $display("FAIL load_bne got %h/%b exp ffffffff/1",
               result_q, taken_q);
    end
    drive(32'h004182b3, 32'd5, 32'd5);
    enable = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (result_q !== 32'hFFFFFFFF || taken_q !== 1'b1) begin
      errors++;
      $display("FAIL hold got %h/%b exp ffffffff/1", result_q, taken_q);
    end
  endtask

  task automatic test_async_clear;
    enable = 1'b1;
    drive(32'h004182b3, 32'd10, 32'd20);
    #1;
    clear = 1'b0;
    #1;
    checks++;
    if (result_q !== 32'h0 || taken_q !== 1'b0) begin
      errors++;
      $display("FAIL clr_async got %h/%b exp 0/0", result_q, taken_q);
    end
    checks++;
    if (aluResult !== 32'd30) begin
      errors++;
      $display("FAIL clr_comb got %h exp %h", aluResult, 32'd30);
    end
    @(posedge clock);
    #1;
    checks++;
    if (result_q !== 32'h0) begin
      errors++;
      $display("FAIL clr_hold got %h exp 0", result_q);
    end
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (result_q !== 32'd30) begin
      errors++;
      $display("FAIL clr_release got %h exp %h", result_q, 32'd30);
    end
  endtask

  initial begin
    clear  = 1'b0;
    enable = 1'b0;
    instr  = 32'h0;
    dataA  = 32'h0;
    dataB  = 32'h0;
    test_reset();
    test_itype();
    test_mem();
    test_rtype();
    test_lui_default();
    test_branch();
    test_output_stage();
    test_async_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
